multicycle_controller: RTL and testbench

- Multi-cycle RV32I control FSM for the shared-memory multicycle datapath: one ALU and one unified instruction/data memory port.
- Sequences each instruction over 3–5 cycles, drives all datapath enables and mux selects, and stalls on the memory handshake.
- Sits beside the datapath and replaces the single-cycle combinational controller in the multicycle core build.

---
 rtl/mc_ctrl_pkg.sv | 72 +++++++
 rtl/mc_alu_dec.sv | 33 +++
 rtl/multicycle_controller.sv | 169 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// ALUOp/ALU control codes, immediate formats and datapath mux selects.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9,
      S_JAL    = 4'd10,
      S_TRAP   = 4'd11
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLT = 4'b0101;
   localparam logic [3:0] ALU_SLL = 4'b0110;
   localparam logic [3:0] ALU_SRL = 4'b0111;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Immediate format depends only on the opcode, independent of FSM state.
   function automatic logic [2:0] imm_src_of(input logic [6:0] op);
      case (op)
         OP_STORE:          imm_src_of = IMM_S;
         OP_BRANCH:         imm_src_of = IMM_B;
         OP_JAL:            imm_src_of = IMM_J;
         OP_LUI, OP_AUIPC:  imm_src_of = IMM_U;
         default:           imm_src_of = IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU decoder: maps ALUOp plus funct fields to the 4-bit ALU operation code.
module mc_alu_dec
   import mc_ctrl_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [3:0] alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_SUB:   alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // I-type (op5 = 0) has no SUB, so funct7b5 of addi is an immediate bit.
               3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b111:  alu_control = ALU_AND;
               3'b110:  alu_control = ALU_OR;
               3'b100:  alu_control = ALU_XOR;
               3'b010:  alu_control = ALU_SLT;
               3'b001:  alu_control = ALU_SLL;
               3'b101:  alu_control = ALU_SRL;
               default: alu_control = ALU_ADD;
            endcase
         end
         default:     alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM for a shared-memory datapath. Define
// MC_ILLEGAL_TRAP_EN to trap on unknown opcodes instead of treating them as NOPs.
module multicycle_controller
   import mc_ctrl_pkg::*;
#(
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] imm_src,
   output logic [3:0] alu_control,
   output logic       trap
);

   state_t     state, next_state;
   logic       mem_req_c, pc_write_c, adr_src_c, mem_write_c;
   logic       ir_write_c, reg_write_c, trap_c;
   logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c, alu_op;
   logic [3:0] alu_control_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= state_t'(RESET_STATE);
      else        state <= next_state;
   end

   always_comb begin
      next_state   = state;
      mem_req_c    = 1'b0;
      pc_write_c   = 1'b0;
      adr_src_c    = 1'b0;
      mem_write_c  = 1'b0;
      ir_write_c   = 1'b0;
      reg_write_c  = 1'b0;
      trap_c       = 1'b0;
      result_src_c = RES_ALUOUT;
      alu_src_a_c  = SRCA_PC;
      alu_src_b_c  = SRCB_RS2;
      alu_op       = ALUOP_ADD;
      case (state)
         S_FETCH: begin
            mem_req_c    = 1'b1;
            alu_src_b_c  = SRCB_FOUR;
            result_src_c = RES_ALURESULT;
            ir_write_c   = mem_ready;
            pc_write_c   = mem_ready;
            if (mem_ready) next_state = S_DECODE;
         end
         S_DECODE: begin
            alu_src_a_c = SRCA_OLDPC;
            alu_src_b_c = SRCB_IMM;
            case (op)
               OP_LOAD, OP_STORE: next_state = S_MEMADR;
               OP_RTYPE:          next_state = S_EXECR;
               OP_ITYPE:          next_state = S_EXECI;
               OP_BRANCH:         next_state = S_BRANCH;
               OP_JAL:            next_state = S_JAL;
`ifdef MC_ILLEGAL_TRAP_EN
               default:           next_state = S_TRAP;
`else
               default:           next_state = S_FETCH;
`endif
            endcase
         end
         S_MEMADR: begin
            alu_src_a_c = SRCA_RS1;
            alu_src_b_c = SRCB_IMM;
            next_state  = (op == OP_STORE) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            mem_req_c = 1'b1;
            adr_src_c = 1'b1;
            if (mem_ready) next_state = S_MEMWB;
         end
         S_MEMWB: begin
            result_src_c = RES_DATA;
            reg_write_c  = 1'b1;
            next_state   = S_FETCH;
         end
         S_MEMWR: begin
            mem_req_c   = 1'b1;
            adr_src_c   = 1'b1;
            mem_write_c = mem_ready;
            if (mem_ready) next_state = S_FETCH;
         end
         S_EXECR: begin
            alu_src_a_c = SRCA_RS1;
            alu_src_b_c = SRCB_RS2;
            alu_op      = ALUOP_FUNCT;
            next_state  = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a_c = SRCA_RS1;
            alu_src_b_c = SRCB_IMM;
            alu_op      = ALUOP_FUNCT;
            next_state  = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write_c = 1'b1;
            next_state  = S_FETCH;
         end
         S_BRANCH: begin
            // Target was computed into ALUOut during DECODE; the ALU compares rs1/rs2 here.
            alu_src_a_c = SRCA_RS1;
            alu_src_b_c = SRCB_RS2;
            alu_op      = ALUOP_SUB;
            case (funct3)
               3'b000:  pc_write_c = zero;
               3'b001:  pc_write_c = ~zero;
               default: pc_write_c = 1'b0;
            endcase
            next_state = S_FETCH;
         end
         S_JAL: begin
            alu_src_a_c = SRCA_OLDPC;
            alu_src_b_c = SRCB_FOUR;
            pc_write_c  = 1'b1;
            next_state  = S_ALUWB;
         end
`ifdef MC_ILLEGAL_TRAP_EN
         S_TRAP: begin
            trap_c     = 1'b1;
            next_state = S_TRAP;
         end
`endif
         default: next_state = S_FETCH;
      endcase
   end

   mc_alu_dec u_alu_dec (
      .alu_op      (alu_op),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .op5         (op[5]),
      .alu_control (alu_control_c)
   );

   // Holding rst_n low must silence every strobe at once, even though state already reads FETCH.
   assign mem_req     = mem_req_c   & rst_n;
   assign pc_write    = pc_write_c  & rst_n;
   assign adr_src     = adr_src_c   & rst_n;
   assign mem_write   = mem_write_c & rst_n;
   assign ir_write    = ir_write_c  & rst_n;
   assign reg_write   = reg_write_c & rst_n;
   assign result_src  = result_src_c  & {2{rst_n}};
   assign alu_src_a   = alu_src_a_c   & {2{rst_n}};
   assign alu_src_b   = alu_src_b_c   & {2{rst_n}};
   assign imm_src     = imm_src_of(op) & {3{rst_n}};
   assign alu_control = alu_control_c & {4{rst_n}};
`ifdef MC_ILLEGAL_TRAP_EN
   assign trap        = trap_c & rst_n;
`else
   assign trap        = trap_c;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction cycle schedules
// built from the instruction class, compared cycle by cycle against the DUT.
module tb_multicycle_controller;

   localparam logic [6:0] T_LOAD  = 7'b0000011;
   localparam logic [6:0] T_STORE = 7'b0100011;
   localparam logic [6:0] T_R     = 7'b0110011;
   localparam logic [6:0] T_I     = 7'b0010011;
   localparam logic [6:0] T_BR    = 7'b1100011;
   localparam logic [6:0] T_JAL   = 7'b1101111;
   localparam logic [6:0] T_ILL   = 7'b1111111;

   localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4,
                  P_MEMWR = 5, P_EXECR = 6, P_EXECI = 7, P_ALUWB = 8, P_BRANCH = 9,
                  P_JAL = 10, P_TRAP = 11;

   typedef struct {
      int ph;
      bit mr;
   } step_t;

   logic       clk, rst_n;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5, zero, mem_ready;
   logic       mem_req, pc_write, adr_src, mem_write, ir_write, reg_write, trap;
   logic [1:0] result_src, alu_src_a, alu_src_b;
   logic [2:0] imm_src;
   logic [3:0] alu_control;
   logic [19:0] act;

   int n_cmp  = 0;
   int n_fail = 0;
   step_t sched[$];

   multicycle_controller dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .pc_write(pc_write),
      .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
      .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_control(alu_control), .trap(trap)
   );

   assign act = {mem_req, pc_write, adr_src, mem_write, ir_write, reg_write,
                 result_src, alu_src_a, alu_src_b, imm_src, alu_control, trap};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] imm_ref(input logic [6:0] o);
      if (o == T_STORE) return 3'b001;
      if (o == T_BR) return 3'b010;
      if (o == T_JAL) return 3'b011;
      if (o == 7'b0110111 || o == 7'b0010111) return 3'b100;
      return 3'b000;
   endfunction

   // ALU operation an R/I instruction asks for, from the ISA meaning of funct3.
   function automatic logic [3:0] alu_ref(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      logic [3:0] tbl [8];
      tbl = '{4'd0, 4'd6, 4'd5, 4'd0, 4'd4, 4'd7, 4'd3, 4'd2};
      if (f3 == 3'b000 && o == T_R && f7) return 4'd1;
      return tbl[f3];
   endfunction

   function automatic logic [19:0] exp_vec(input int ph, input logic [6:0] o, input logic [2:0] f3,
                                           input logic f7, input logic z, input logic mr);
      logic mreq, pcw, adr, mw, irw, rw, tr;
      logic [1:0] rs, sa, sb;
      logic [3:0] alu;
      {mreq, pcw, adr, mw, irw, rw, tr} = '0;
      rs = 2'd0; sa = 2'd0; sb = 2'd0; alu = 4'd0;
      case (ph)
         P_FETCH:  begin mreq = 1; sb = 2; rs = 2; irw = mr; pcw = mr; end
         P_DECODE: begin sa = 1; sb = 1; end
         P_MEMADR: begin sa = 2; sb = 1; end
         P_MEMRD:  begin mreq = 1; adr = 1; end
         P_MEMWB:  begin rs = 1; rw = 1; end
         P_MEMWR:  begin mreq = 1; adr = 1; mw = mr; end
         P_EXECR:  begin sa = 2; sb = 0; alu = alu_ref(o, f3, f7); end
         P_EXECI:  begin sa = 2; sb = 1; alu = alu_ref(o, f3, f7); end
         P_ALUWB:  rw = 1;
         P_BRANCH: begin sa = 2; alu = 4'd1; pcw = (f3 == 3'd0) ? z : (f3 == 3'd1) ? ~z : 1'b0; end
         P_JAL:    begin sa = 1; sb = 2; pcw = 1; end
         P_TRAP:   tr = 1;
         default:  ;
      endcase
      return {mreq, pcw, adr, mw, irw, rw, rs, sa, sb, imm_ref(o), alu, tr};
   endfunction

   task automatic push_wait(input int ph, input int waits);
      for (int i = 0; i < waits; i++) sched.push_back('{ph, 1'b0});
      sched.push_back('{ph, 1'b1});
   endtask

   task automatic push_plain(input int ph);
      sched.push_back('{ph, 1'($urandom_range(0, 1))});
   endtask

   // Runs the scheduled cycles; entered and left just after a rising edge.
   task automatic run_sched(input string tag, input logic z);
      while (sched.size() > 0) begin
         step_t s;
         logic [19:0] e;
         s = sched.pop_front();
         mem_ready = s.mr;
         @(negedge clk);
         e = exp_vec(s.ph, op, funct3, funct7b5, z, s.mr);
         n_cmp++;
         if (act !== e) begin
            n_fail++;
            $display("FAIL %s phase=%0d: got %b expected %b", tag, s.ph, act, e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                            input logic f7, input logic z, input int fw, input int mw);
      op = o; funct3 = f3; funct7b5 = f7; zero = z;
      sched.delete();
      push_wait(P_FETCH, fw);
      push_plain(P_DECODE);
      case (o)
         T_LOAD:  begin push_plain(P_MEMADR); push_wait(P_MEMRD, mw); push_plain(P_MEMWB); end
         T_STORE: begin push_plain(P_MEMADR); push_wait(P_MEMWR, mw); end
         T_R:     begin push_plain(P_EXECR); push_plain(P_ALUWB); end
         T_I:     begin push_plain(P_EXECI); push_plain(P_ALUWB); end
         T_BR:    push_plain(P_BRANCH);
         T_JAL:   begin push_plain(P_JAL); push_plain(P_ALUWB); end
         default: begin
`ifdef MC_ILLEGAL_TRAP_EN
            for (int i = 0; i < 4; i++) push_plain(P_TRAP);
`endif
         end
      endcase
      run_sched(tag, z);
   endtask

   task automatic check_fetch_idle(input string tag);
      sched.delete();
      sched.push_back('{P_FETCH, 1'b0});
      run_sched(tag, zero);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; mem_ready = 1'b0; op = T_LOAD; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (act !== 20'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b expected %b", act, 20'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_fetch_idle("reset_release_fetch");
   endtask

   task automatic test_load;
      run_instr("lw_ready", T_LOAD, 3'b010, 1'b0, 1'b0, 0, 0);
      run_instr("lw_waits", T_LOAD, 3'b010, 1'b0, 1'b0, 2, 3);
   endtask

   task automatic test_store;
      run_instr("sw_wait3", T_STORE, 3'b010, 1'b0, 1'b0, 0, 3);
   endtask

   task automatic test_alu;
      run_instr("add", T_R, 3'b000, 1'b0, 1'b0, 0, 0);
      run_instr("sub", T_R, 3'b000, 1'b1, 1'b0, 0, 0);
      run_instr("addi_f7", T_I, 3'b000, 1'b1, 1'b0, 0, 0);
      for (int f = 1; f < 8; f++) begin
         run_instr("rtype_f3", T_R, 3'(f), 1'($urandom_range(0, 1)), 1'b0, 0, 0);
         run_instr("itype_f3", T_I, 3'(f), 1'($urandom_range(0, 1)), 1'b0, 0, 0);
      end
   endtask

   task automatic test_branch;
      run_instr("beq_taken", T_BR, 3'b000, 1'b0, 1'b1, 0, 0);
      run_instr("beq_not", T_BR, 3'b000, 1'b0, 1'b0, 0, 0);
      run_instr("bne_z1", T_BR, 3'b001, 1'b0, 1'b1, 0, 0);
      run_instr("bne_z0", T_BR, 3'b001, 1'b0, 1'b0, 0, 0);
      run_instr("blt_f3_100", T_BR, 3'b100, 1'b0, 1'b1, 0, 0);
   endtask

   task automatic test_jal;
      run_instr("jal", T_JAL, 3'b000, 1'b0, 1'b0, 1, 0);
   endtask

   task automatic test_reset_mid_access;
      op = T_LOAD; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
      sched.delete();
      push_wait(P_FETCH, 0);
      push_plain(P_DECODE);
      push_plain(P_MEMADR);
      sched.push_back('{P_MEMRD, 1'b0});
      run_sched("mid_reset_lead", 1'b0);
      mem_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({mem_req, pc_write, reg_write, mem_write} !== 4'b0000) begin
         n_fail++;
         $display("FAIL mid_reset_async: got %b expected 0000", {mem_req, pc_write, reg_write, mem_write});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_fetch_idle("mid_reset_fetch");
   endtask

   task automatic test_illegal;
      run_instr("illegal_op", T_ILL, 3'b000, 1'b0, 1'b0, 0, 0);
`ifdef MC_ILLEGAL_TRAP_EN
      #2 rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
`endif
      check_fetch_idle("after_illegal_fetch");
   endtask

   task automatic test_random;
      logic [6:0] ops [6];
      ops = '{T_LOAD, T_STORE, T_R, T_I, T_BR, T_JAL};
      for (int n = 0; n < 40; n++) begin
         run_instr("random", ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), $urandom_range(0, 3));
      end
      check_fetch_idle("random_tail_fetch");
   endtask

   initial begin
      test_reset();
      test_load();
      test_store();
      test_alu();
      test_branch();
      test_jal();
      test_reset_mid_access();
      test_illegal();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
